// File: rtl/alu_reg_sequencer.sv
//==============================================================================
// Module      : alu_reg_sequencer
// Description : Issue/writeback sequencer for an external combinational ALU,
//               with a 4-entry register file, load-immediate and readout.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module alu_reg_sequencer #(
    parameter int              WIDTH      = 8,
    parameter logic [WIDTH-1:0] DIV0_VALUE = WIDTH'(8'hFF)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [11:0]      instr,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             err_div0,
    output logic             err_illegal,
    input  logic [1:0]       dbg_sel,
    output logic [WIDTH-1:0] dbg_data
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    localparam logic [1:0] c_KIND_ALU = 2'b00;
    localparam logic [1:0] c_KIND_LDI = 2'b01;
    localparam logic [1:0] c_KIND_OUT = 2'b10;
    localparam logic [3:0] c_OP_DIV   = 4'b0011;

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_regs [4];
    logic [1:0]       r_rd;

    logic       w_accept;
    logic [1:0] w_kind;
    logic       w_div0;

    assign instr_ready = (r_state == ST_IDLE) && !reset;
    assign w_accept    = instr_valid && instr_ready;
    assign w_kind      = instr[11:10];
    // Divide-by-zero is judged on the operands actually presented to the ALU.
    assign w_div0      = (alu_ctrl == c_OP_DIV) && (alu_b == '0);
    assign dbg_data    = r_regs[dbg_sel];

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_kind == c_KIND_ALU)
                        w_next_state = ST_EXEC;
                    else if (w_kind == c_KIND_OUT)
                        w_next_state = ST_OUT;
                end
            end
            ST_EXEC: w_next_state = ST_IDLE;
            ST_OUT: begin
                if (out_ready)
                    w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_next_state;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++)
                r_regs[i] <= '0;
            r_rd        <= '0;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_ctrl    <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            err_div0    <= 1'b0;
            err_illegal <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        case (w_kind)
                            c_KIND_ALU: begin
                                alu_a    <= r_regs[instr[3:2]];
                                alu_b    <= r_regs[instr[1:0]];
                                alu_ctrl <= instr[9:6];
                                r_rd     <= instr[5:4];
                            end
                            c_KIND_LDI: r_regs[instr[9:8]] <= WIDTH'(instr[7:0]);
                            c_KIND_OUT: begin
                                out_data  <= r_regs[instr[1:0]];
                                out_valid <= 1'b1;
                            end
                            default: err_illegal <= 1'b1;
                        endcase
                    end
                end
                ST_EXEC: begin
                    if (w_div0) begin
                        r_regs[r_rd] <= DIV0_VALUE;
                        err_div0     <= 1'b1;
                    end else begin
                        r_regs[r_rd] <= alu_result;
                    end
                end
                ST_OUT: begin
                    if (out_ready)
                        out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_reg_sequencer.sv
//==============================================================================
// Module      : tb_alu_reg_sequencer
// Description : Scoreboard bench for alu_reg_sequencer with a behavioural ALU.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_alu_reg_sequencer;

    logic        clk;
    logic        reset;
    logic        instr_valid;
    logic        instr_ready;
    logic [11:0] instr;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [3:0]  alu_ctrl;
    logic [7:0]  alu_result;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        err_div0;
    logic        err_illegal;
    logic [1:0]  dbg_sel;
    logic [7:0]  dbg_data;

    typedef struct {
        logic [1:0] rd;
        logic [7:0] val;
    } wb_t;

    wb_t        sb_q [$];
    logic [7:0] out_q [$];
    logic [7:0] m_regs [4];
    logic       m_div0;
    int         n_checks = 0;
    int         n_fail   = 0;

    alu_reg_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_ctrl    (alu_ctrl),
        .alu_result  (alu_result),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .err_div0    (err_div0),
        .err_illegal (err_illegal),
        .dbg_sel     (dbg_sel),
        .dbg_data    (dbg_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural stand-in for the downstream ALU.
    function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                          input logic [3:0] op);
        logic [15:0] p;
        case (op)
            4'b0000: return a + b;
            4'b0001: return a - b;
            4'b0010: begin p = a * b; return p[7:0]; end
            4'b0011: return (b == 8'd0) ? 8'd0 : a / b;
            4'b0100: return a & b;
            4'b0101: return a | b;
            4'b0110: return (a > b) ? 8'd1 : 8'd0;
            default: return a ^ b;
        endcase
    endfunction

    assign alu_result = alu_fn(alu_a, alu_b, alu_ctrl);

    function automatic logic [11:0] enc_alu(input logic [3:0] op, input logic [1:0] rd,
                                            input logic [1:0] rs1, input logic [1:0] rs2);
        return {2'b00, op, rd, rs1, rs2};
    endfunction

    function automatic logic [11:0] enc_ldi(input logic [1:0] rd, input logic [7:0] imm);
        return {2'b01, rd, imm};
    endfunction

    function automatic logic [11:0] enc_out(input logic [1:0] rs);
        return {2'b10, 8'h00, rs};
    endfunction

    // Presents one instruction and returns 1 time unit after its accept edge.
    task automatic issue(input logic [11:0] w);
        int waited = 0;
        while (!instr_ready && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!instr_ready) begin
            n_checks++; n_fail++;
            $display("FAIL issue_timeout: instr_ready=%b required 1", instr_ready);
        end
        instr       = w;
        instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
    endtask

    task automatic ldi(input logic [1:0] rd, input logic [7:0] imm);
        issue(enc_ldi(rd, imm));
        m_regs[rd] = imm;
    endtask

    // Issues an ALU op, records EXEC-cycle outputs, returns after writeback edge.
    task automatic do_alu(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                          input logic [1:0] rs2, output logic [7:0] ea, output logic [7:0] eb,
                          output logic [3:0] ec, output logic erdy);
        logic [7:0] a, b, r;
        wb_t        e;
        a = m_regs[rs1];
        b = m_regs[rs2];
        if (op == 4'b0011 && b == 8'd0) begin
            r = 8'hFF;
            m_div0 = 1'b1;
        end else begin
            r = alu_fn(a, b, op);
        end
        e.rd = rd; e.val = r;
        sb_q.push_back(e);
        m_regs[rd] = r;
        issue(enc_alu(op, rd, rs1, rs2));
        ea = alu_a; eb = alu_b; ec = alu_ctrl; erdy = instr_ready;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; instr_valid = 1'b0; instr = '0; out_ready = 1'b0; dbg_sel = '0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (instr_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b want 0", instr_ready); end
        n_checks++; if ({alu_a, alu_b, alu_ctrl} !== 20'h0) begin n_fail++; $display("FAIL rst_alu: got %h want 0", {alu_a, alu_b, alu_ctrl}); end
        n_checks++; if ({out_valid, out_data, err_div0, err_illegal} !== 11'h0) begin n_fail++; $display("FAIL rst_out_err: got %h want 0", {out_valid, out_data, err_div0, err_illegal}); end
        for (int i = 0; i < 4; i++) begin
            dbg_sel = 2'(i); #1;
            n_checks++; if (dbg_data !== 8'h00) begin n_fail++; $display("FAIL rst_reg%0d: got %h want 00", i, dbg_data); end
            m_regs[i] = 8'h00;
        end
        m_div0 = 1'b0;
        reset = 1'b0; #1;
        n_checks++; if (instr_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready: got %b want 1", instr_ready); end
    endtask

    task automatic test_add();
        logic [7:0] a, b; logic [3:0] c; logic rdy; wb_t e;
        ldi(2'd0, 8'h05);
        ldi(2'd1, 8'h03);
        do_alu(4'b0000, 2'd2, 2'd0, 2'd1, a, b, c, rdy);
        n_checks++; if (a !== 8'h05 || b !== 8'h03 || c !== 4'h0) begin n_fail++; $display("FAIL add_operands: got a=%h b=%h c=%h want 05 03 0", a, b, c); end
        n_checks++; if (rdy !== 1'b0) begin n_fail++; $display("FAIL add_exec_ready: got %b want 0", rdy); end
        n_checks++; if (instr_ready !== 1'b1) begin n_fail++; $display("FAIL add_ready_after: got %b want 1", instr_ready); end
        e = sb_q.pop_front(); dbg_sel = e.rd; #1;
        n_checks++; if (dbg_data !== e.val) begin n_fail++; $display("FAIL add_wb: got %h want %h", dbg_data, e.val); end
    endtask

    task automatic test_mul_truncate();
        logic [7:0] a, b; logic [3:0] c; logic rdy; wb_t e;
        ldi(2'd0, 8'h80);
        ldi(2'd1, 8'h02);
        do_alu(4'b0010, 2'd3, 2'd0, 2'd1, a, b, c, rdy);
        e = sb_q.pop_front(); dbg_sel = e.rd; #1;
        n_checks++; if (dbg_data !== e.val) begin n_fail++; $display("FAIL mul_wb: got %h want %h", dbg_data, e.val); end
        do_alu(4'b0110, 2'd3, 2'd0, 2'd1, a, b, c, rdy);
        n_checks++; if (c !== 4'b0110) begin n_fail++; $display("FAIL cmp_ctrl: got %h want 6", c); end
        e = sb_q.pop_front(); dbg_sel = e.rd; #1;
        n_checks++; if (dbg_data !== e.val) begin n_fail++; $display("FAIL cmp_wb: got %h want %h", dbg_data, e.val); end
    endtask

    task automatic test_div0();
        logic [7:0] a, b; logic [3:0] c; logic rdy; wb_t e;
        ldi(2'd1, 8'h00);
        do_alu(4'b0011, 2'd2, 2'd0, 2'd1, a, b, c, rdy);
        e = sb_q.pop_front(); dbg_sel = e.rd; #1;
        n_checks++; if (dbg_data !== e.val) begin n_fail++; $display("FAIL div0_wb: got %h want %h", dbg_data, e.val); end
        n_checks++; if (err_div0 !== m_div0) begin n_fail++; $display("FAIL div0_flag: got %b want %b", err_div0, m_div0); end
        ldi(2'd0, 8'h06);
        ldi(2'd1, 8'h03);
        do_alu(4'b0011, 2'd2, 2'd0, 2'd1, a, b, c, rdy);
        e = sb_q.pop_front(); dbg_sel = e.rd; #1;
        n_checks++; if (dbg_data !== e.val) begin n_fail++; $display("FAIL div_wb: got %h want %h", dbg_data, e.val); end
        n_checks++; if (err_div0 !== 1'b1) begin n_fail++; $display("FAIL div0_sticky: got %b want 1", err_div0); end
    endtask

    task automatic test_out_backpressure();
        logic [7:0] exp;
        issue(enc_out(2'd2));
        out_q.push_back(m_regs[2]);
        for (int i = 0; i < 5; i++) begin
            n_checks++; if (out_valid !== 1'b1 || out_data !== out_q[0]) begin n_fail++; $display("FAIL out_hold%0d: got v=%b d=%h want 1 %h", i, out_valid, out_data, out_q[0]); end
            n_checks++; if (instr_ready !== 1'b0) begin n_fail++; $display("FAIL out_ready_low%0d: got %b want 0", i, instr_ready); end
            instr_valid = (i % 2) == 1;
            instr = enc_ldi(2'd0, 8'h55);
            @(posedge clk); #1;
            instr_valid = 1'b0;
        end
        out_ready = 1'b1;
        exp = out_q.pop_front();
        n_checks++; if (out_data !== exp) begin n_fail++; $display("FAIL out_handshake: got %h want %h", out_data, exp); end
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_checks++; if (out_valid !== 1'b0 || instr_ready !== 1'b1) begin n_fail++; $display("FAIL out_release: got v=%b rdy=%b want 0 1", out_valid, instr_ready); end
        dbg_sel = 2'd0; #1;
        n_checks++; if (dbg_data !== m_regs[0]) begin n_fail++; $display("FAIL out_ignored_instr: got %h want %h", dbg_data, m_regs[0]); end
    endtask

    task automatic test_back_to_back();
        issue(12'hC00);
        n_checks++; if (err_illegal !== 1'b1) begin n_fail++; $display("FAIL illegal_flag: got %b want 1", err_illegal); end
        for (int i = 0; i < 4; i++) begin
            dbg_sel = 2'(i); #1;
            n_checks++; if (dbg_data !== m_regs[i]) begin n_fail++; $display("FAIL illegal_reg%0d: got %h want %h", i, dbg_data, m_regs[i]); end
        end
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (instr_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready%0d: got %b want 1", i, instr_ready); end
            ldi(2'(i), 8'(i + 1));
        end
        for (int i = 0; i < 4; i++) begin
            dbg_sel = 2'(i); #1;
            n_checks++; if (dbg_data !== m_regs[i]) begin n_fail++; $display("FAIL b2b_reg%0d: got %h want %h", i, dbg_data, m_regs[i]); end
        end
    endtask

    task automatic test_reset_mid_exec();
        ldi(2'd1, 8'h07);
        issue(enc_alu(4'b0000, 2'd1, 2'd0, 2'd2));
        reset = 1'b1; #1;
        n_checks++; if (instr_ready !== 1'b0) begin n_fail++; $display("FAIL rst_exec_ready: got %b want 0", instr_ready); end
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
        m_div0 = 1'b0;
        reset = 1'b0;
        @(posedge clk); #1;
        dbg_sel = 2'd1; #1;
        n_checks++; if (dbg_data !== m_regs[1]) begin n_fail++; $display("FAIL rst_exec_no_wb: got %h want %h", dbg_data, m_regs[1]); end
        n_checks++; if (err_div0 !== m_div0 || err_illegal !== 1'b0) begin n_fail++; $display("FAIL rst_exec_flags: got %b%b want 00", err_div0, err_illegal); end
        n_checks++; if (instr_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_exec_idle: got rdy=%b v=%b want 1 0", instr_ready, out_valid); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_mul_truncate();
        test_div0();
        test_out_backpressure();
        test_back_to_back();
        test_reset_mid_exec();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
